// File: rtl/eth_udp_rx.sv
// rtl/eth_udp_rx.sv - Ethernet/VLAN/IPv4/UDP receive header stripper.
// Checks and strips the L2/L3/L4 headers and streams the UDP payload with 1-cycle latency.
module eth_udp_rx #(
  parameter int          IS_10G            = 1,
  parameter int          VLAN_TAG          = 1,
  parameter int          DATA_W            = 16,
  parameter int          MATCH_IP_SRC_ADDR = 1,
  parameter int          MATCH_IP_DST_ADDR = 1,
  parameter logic [31:0] IP_SRC_ADDR       = 32'h1,
  parameter logic [31:0] IP_DST_ADDR       = 32'h0,
  localparam int         KEEP_W            = DATA_W / 8,
  localparam int         LEN_W             = $clog2(KEEP_W + 1),
  localparam int         LANE0_CNT_N       = (IS_10G != 0 && DATA_W == 64) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   phy_cancel_i,
  input  logic                   mac_valid_i,
  input  logic [DATA_W-1:0]      mac_data_i,
  input  logic [LANE0_CNT_N-1:0] mac_start_i,
  input  logic                   mac_term_i,
  input  logic [LEN_W-1:0]       mac_len_i,
  output logic                   app_valid_o,
  output logic                   app_start_o,
  output logic                   app_cancel_o,
  output logic [DATA_W-1:0]      app_data_o,
  output logic [LEN_W-1:0]       app_len_o
);

  localparam int IP_B      = (VLAN_TAG != 0) ? 18 : 14;
  localparam int HDR_WORDS = (IP_B + 28) / KEEP_W;
  localparam int CNT_W     = $clog2(HDR_WORDS + 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, word_idx;
  logic              first_q, first_d;
  logic              hdr_ok, is_start;
  logic              valid_d, start_d, cancel_d;
  logic [DATA_W-1:0] data_d;
  logic [LEN_W-1:0]  len_d;

  // Expected value of frame byte idx; bytes not listed here are unchecked.
  function automatic logic byte_ok(input int idx, input logic [7:0] b);
    logic [31:0] addr;
    addr = '0;
    if (VLAN_TAG != 0 && idx == 12) return b == 8'h81;
    if (VLAN_TAG != 0 && idx == 13) return b == 8'h00;
    if (idx == IP_B - 2)            return b == 8'h08;
    if (idx == IP_B - 1)            return b == 8'h00;
    if (idx == IP_B)                return b == 8'h45;
    if (idx == IP_B + 9)            return b == 8'h11;
    if (MATCH_IP_SRC_ADDR != 0 && idx >= IP_B + 12 && idx <= IP_B + 15) begin
      addr = IP_SRC_ADDR >> (8 * (IP_B + 15 - idx));
      return b == addr[7:0];
    end
    if (MATCH_IP_DST_ADDR != 0 && idx >= IP_B + 16 && idx <= IP_B + 19) begin
      addr = IP_DST_ADDR >> (8 * (IP_B + 19 - idx));
      return b == addr[7:0];
    end
    return 1'b1;
  endfunction

  assign is_start = mac_valid_i && (|mac_start_i);
  assign word_idx = is_start ? '0 : cnt_q;

  always_comb begin
    hdr_ok = 1'b1;
    for (int lane = 0; lane < KEEP_W; lane++) begin
      if (!byte_ok(int'(word_idx) * KEEP_W + lane, mac_data_i[8*lane +: 8])) hdr_ok = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    cancel_d = 1'b0;
    data_d   = mac_data_i;
    len_d    = LEN_W'(KEEP_W);
    if (phy_cancel_i) begin
      cancel_d = (state_q == PAYLOAD);
      state_d  = IDLE;
      cnt_d    = '0;
    end else if (is_start) begin
      // A new frame while forwarding means the old one lost its term.
      cancel_d = (state_q == PAYLOAD);
      if (mac_term_i) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (!hdr_ok) begin
        state_d = DROP;
        cnt_d   = '0;
      end else begin
        state_d = HDR;
        cnt_d   = CNT_W'(1);
      end
    end else if (mac_valid_i) begin
      case (state_q)
        HDR: begin
          if (mac_term_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (!hdr_ok) begin
            state_d = DROP;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(HDR_WORDS - 1)) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAYLOAD: begin
          valid_d = 1'b1;
          start_d = first_q;
          first_d = 1'b0;
          if (mac_term_i) begin
            len_d   = mac_len_i;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (mac_term_i) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      app_valid_o  <= 1'b0;
      app_start_o  <= 1'b0;
      app_cancel_o <= 1'b0;
      app_data_o   <= '0;
      app_len_o    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      app_valid_o  <= valid_d;
      app_start_o  <= start_d;
      app_cancel_o <= cancel_d;
      app_data_o   <= data_d;
      app_len_o    <= len_d;
    end
  end

endmodule

// File: tb/tb_eth_udp_rx.sv
// tb/tb_eth_udp_rx.sv - randomized scoreboard bench for eth_udp_rx.
// Expected beats come from a byte-level model of the frame; a monitor pops and compares.
module tb_eth_udp_rx;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    bit          cancel;
    bit          start;
    logic [1:0]  len;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        phy_cancel_i = 1'b0;
  logic        mac_valid_i = 1'b0;
  logic [15:0] mac_data_i = '0;
  logic [0:0]  mac_start_i = '0;
  logic        mac_term_i = 1'b0;
  logic [1:0]  mac_len_i = '0;
  logic        app_valid_o, app_start_o, app_cancel_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  logic rst_q = 1'b0;

  eth_udp_rx dut (
    .clk(clk), .nreset(nreset), .phy_cancel_i(phy_cancel_i),
    .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i), .mac_start_i(mac_start_i),
    .mac_term_i(mac_term_i), .mac_len_i(mac_len_i),
    .app_valid_o(app_valid_o), .app_start_o(app_start_o), .app_cancel_o(app_cancel_o),
    .app_data_o(app_data_o), .app_len_o(app_len_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= nreset;

  // Monitor: reset-state checks, scoreboard pops, final drain check.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] m;
    bit          ok;
    if (done) begin
      n_tests++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected outputs never appeared, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else if (rst_q) begin
      n_tests++;
      if (app_valid_o !== 1'b0 || app_start_o !== 1'b0 || app_cancel_o !== 1'b0 ||
          app_data_o !== 16'h0 || app_len_o !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b start=%b cancel=%b data=%h len=%0d, required all 0",
                 app_valid_o, app_start_o, app_cancel_o, app_data_o, app_len_o);
      end
    end else if (app_valid_o === 1'b1 || app_cancel_o === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got valid=%b cancel=%b len=%0d data=%h, required nothing",
                 app_valid_o, app_cancel_o, app_len_o, app_data_o);
      end else begin
        e = sb.pop_front();
        m = (e.len == 2'd2) ? 16'hffff : (e.len == 2'd1) ? 16'h00ff : 16'h0000;
        if (e.cancel)
          ok = (app_cancel_o === 1'b1) && (app_valid_o === 1'b0);
        else
          ok = (app_valid_o === 1'b1) && (app_cancel_o === 1'b0) && (app_start_o === e.start) &&
               (app_len_o === e.len) && (((app_data_o ^ e.data) & m) === 16'h0);
        if (!ok) begin
          n_fail++;
          $display("FAIL beat: got valid=%b start=%b cancel=%b len=%0d data=%h, required cancel=%b start=%b len=%0d data=%h",
                   app_valid_o, app_start_o, app_cancel_o, app_len_o, app_data_o,
                   e.cancel, e.start, e.len, e.data & m);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mac_valid_i  = 1'b0;
    phy_cancel_i = 1'b0;
    mac_start_i  = 1'($urandom_range(0, 1));
    mac_term_i   = 1'($urandom_range(0, 1));
    mac_len_i    = 2'($urandom_range(0, 2));
    mac_data_i   = 16'($urandom);
  endtask

  // err: 0 good, 1 src IP 0.0.0.2, 2 protocol TCP, 3 EtherType IPv6, 4 bad dst IP.
  function automatic byte_q_t make_frame(input int plen, input int err);
    byte_q_t f;
    for (int i = 0; i < 46 + plen; i++) f.push_back(8'($urandom));
    f[12] = 8'h81; f[13] = 8'h00; f[16] = 8'h08; f[17] = 8'h00;
    f[18] = 8'h45; f[27] = 8'h11;
    f[30] = 8'h00; f[31] = 8'h00; f[32] = 8'h00; f[33] = 8'h01;
    f[34] = 8'h00; f[35] = 8'h00; f[36] = 8'h00; f[37] = 8'h00;
    case (err)
      1: f[33] = 8'h02;
      2: f[27] = 8'h06;
      3: begin f[16] = 8'h86; f[17] = 8'hdd; end
      4: f[35] = 8'($urandom_range(1, 255));
      default: ;
    endcase
    return f;
  endfunction

  // mode: 0 whole frame, 1 phy cancel on payload word c, 2 stop after c payload words with no term,
  // 3 reset after c payload words, 4 phy cancel on header word c.
  task automatic push_expected(input byte_q_t f, input int mode, input int c);
    int   blen, plen, nb, limit;
    bit   good;
    exp_t e;
    blen = f.size();
    if (blen < 46 || mode == 4) return;
    good = f[12] == 8'h81 && f[13] == 8'h00 && f[16] == 8'h08 && f[17] == 8'h00 &&
           f[18] == 8'h45 && f[27] == 8'h11 &&
           {f[30], f[31], f[32], f[33]} == 32'h1 && {f[34], f[35], f[36], f[37]} == 32'h0;
    if (!good) return;
    plen  = blen - 46;
    nb    = plen / 2 + 1;
    limit = (mode == 0) ? nb : c;
    for (int k = 0; k < limit; k++) begin
      e.cancel = 1'b0;
      e.start  = (k == 0);
      e.len    = (k < plen / 2) ? 2'd2 : 2'(plen % 2);
      e.data   = {(46 + 2*k + 1 < blen) ? f[46 + 2*k + 1] : 8'h00,
                  (46 + 2*k < blen) ? f[46 + 2*k] : 8'h00};
      sb.push_back(e);
    end
    if (mode == 1 || mode == 2) begin
      e.cancel = 1'b1; e.start = 1'b0; e.len = 2'd0; e.data = 16'h0;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input byte_q_t f, input int mode, input int c, input bit gaps);
    int blen, nw, stop;
    blen = f.size();
    nw   = blen / 2 + 1;
    stop = (mode == 0) ? nw : (mode == 4) ? c + 1 : (mode == 1) ? 23 + c + 1 : 23 + c;
    push_expected(f, mode, c);
    for (int w = 0; w < stop; w++) begin
      if (gaps && w > 0) repeat ($urandom_range(0, 3)) cyc();
      mac_valid_i  = 1'b1;
      mac_start_i  = 1'(w == 0);
      mac_term_i   = (w == nw - 1);
      mac_len_i    = (w == nw - 1) ? 2'(blen % 2) : 2'd2;
      mac_data_i   = {(2*w + 1 < blen) ? f[2*w + 1] : 8'($urandom),
                      (2*w < blen) ? f[2*w] : 8'($urandom)};
      phy_cancel_i = (mode == 1 || mode == 4) && (w == stop - 1);
      cyc();
      idle_inputs();
    end
    if (mode == 3) begin
      nreset = 1'b1;
      repeat (3) cyc();
      nreset = 1'b0;
    end
  endtask

  initial begin
    byte_q_t f;
    int      mode, plen, err, c;
    bit      gaps;
    idle_inputs();
    repeat (3) cyc();
    nreset = 1'b0;
    cyc();
    send_frame(make_frame(10, 0), 0, 0, 1'b0);
    send_frame(make_frame(9, 0), 0, 0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      send_frame(make_frame(8, e), 0, 0, 1'b0);
      send_frame(make_frame(7, 0), 0, 0, 1'b0);
    end
    send_frame(make_frame(10, 0), 1, 2, 1'b0);
    f = make_frame(0, 0);
    while (f.size() > 30) void'(f.pop_back());
    send_frame(f, 0, 0, 1'b0);
    send_frame(make_frame(0, 0), 0, 0, 1'b0);
    send_frame(make_frame(11, 0), 0, 0, 1'b1);
    send_frame(make_frame(12, 0), 2, 3, 1'b1);
    send_frame(make_frame(12, 0), 3, 3, 1'b0);
    send_frame(make_frame(6, 0), 0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      mode = (i == 39) ? 0 : $urandom_range(0, 4);
      plen = $urandom_range(0, 20);
      err  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      c    = (mode == 4) ? $urandom_range(1, 21) : $urandom_range(0, plen / 2);
      gaps = 1'($urandom_range(0, 1));
      f    = make_frame(plen, err);
      if (mode == 0 && $urandom_range(0, 9) == 0) begin
        while (f.size() > $urandom_range(20, 45)) void'(f.pop_back());
      end
      send_frame(f, mode, c, gaps);
      repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (5) cyc();
    done = 1'b1;
    repeat (5) cyc();
    $display("FAIL monitor_stall: summary not reached, required monitor to finish");
    $fatal(1);
  end

endmodule
